// File: rtl/write_combiner.sv
// write_combiner: merges consecutive partial-word stores to one address into a
// single masked word write. At most one pending word is held. It is written
// downstream on an address change, on any read, on i_flush, or after TIMEOUT
// idle cycles. Reads are issued only after the held word has been written, so
// read-after-write ordering is kept.
`timescale 1ns/1ps
module write_combiner #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT       = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  output logic                     o_empty,
  output logic                     o_bus_rw,
  output logic                     o_bus_request,
  input  logic                     i_bus_ready,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [31:0]              o_bus_wdata,
  output logic [3:0]               o_bus_wmask,
  input  logic [31:0]              i_bus_rdata,
  input  logic                     i_rw,
  input  logic                     i_request,
  output logic                     o_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wmask,
  output logic [31:0]              o_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_GAP   = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // Last idle_count value before the automatic flush fires.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // Byte-lane merge: lanes selected by mask take the new data, others keep base.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = base;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        result[8*b +: 8] = data[8*b +: 8];
      end else begin
        result[8*b +: 8] = base[8*b +: 8];
      end
    end
    return result;
  endfunction

  state_t                   state_q, state_d;
  logic                     hold_valid_q, hold_valid_d;
  logic [ADDRESS_WIDTH-1:0] hold_address_q, hold_address_d;
  logic [31:0]              hold_wdata_q, hold_wdata_d;
  logic [3:0]               hold_wmask_q, hold_wmask_d;
  logic [7:0]               idle_count_q, idle_count_d;
  logic                     addr_match_s;

  assign addr_match_s = (i_address == hold_address_q);

  // State and hold register update; reset discards any held word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      hold_valid_q   <= 1'b0;
      hold_address_q <= '0;
      hold_wdata_q   <= 32'h0000_0000;
      hold_wmask_q   <= 4'b0000;
      idle_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      hold_valid_q   <= hold_valid_d;
      hold_address_q <= hold_address_d;
      hold_wdata_q   <= hold_wdata_d;
      hold_wmask_q   <= hold_wmask_d;
      idle_count_q   <= idle_count_d;
    end
  end

  // Next-state logic: request arbitration in IDLE, handshakes elsewhere.
  always_comb begin
    state_d        = state_q;
    hold_valid_d   = hold_valid_q;
    hold_address_d = hold_address_q;
    hold_wdata_d   = hold_wdata_q;
    hold_wmask_d   = hold_wmask_q;
    idle_count_d   = idle_count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_flush && hold_valid_q) begin
          state_d = ST_FLUSH;
        end else if (i_request && i_rw && (!hold_valid_q || addr_match_s)) begin
          // A fresh load starts from an empty word so stale lanes never leak.
          hold_valid_d   = 1'b1;
          hold_address_d = i_address;
          hold_wdata_d   = merge_bytes(hold_valid_q ? hold_wdata_q : 32'h0000_0000,
                                       i_wdata, i_wmask);
          hold_wmask_d   = (hold_valid_q ? hold_wmask_q : 4'b0000) | i_wmask;
          idle_count_d   = 8'd0;
          state_d        = ST_ACK;
        end else if (i_request && i_rw) begin
          // Different address: write out the old word; the store stays pending.
          state_d = ST_FLUSH;
        end else if (i_request) begin
          state_d = hold_valid_q ? ST_FLUSH : ST_READ;
        end else if (hold_valid_q && (idle_count_q == TIMEOUT_LAST)) begin
          state_d = ST_FLUSH;
        end else if (hold_valid_q) begin
          idle_count_d = idle_count_q + 8'd1;
        end else begin
          idle_count_d = idle_count_q;
        end
      end
      ST_ACK: begin
        if (!i_request) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_FLUSH: begin
        if (i_bus_ready) begin
          hold_valid_d = 1'b0;
          idle_count_d = 8'd0;
          state_d      = ST_GAP;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        if (!i_request) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state and hold register.
  always_comb begin
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = 32'h0000_0000;
    o_bus_wmask   = 4'b0000;
    o_ready       = 1'b0;
    o_rdata       = i_bus_rdata;
    o_empty       = !hold_valid_q && (state_q != ST_FLUSH) && (state_q != ST_GAP);
    case (state_q)
      ST_ACK: begin
        o_ready = 1'b1;
      end
      ST_FLUSH: begin
        o_bus_request = 1'b1;
        o_bus_rw      = 1'b1;
        o_bus_address = hold_address_q;
        o_bus_wdata   = hold_wdata_q;
        o_bus_wmask   = hold_wmask_q;
      end
      ST_READ: begin
        o_bus_request = 1'b1;
        o_bus_rw      = 1'b0;
        o_bus_address = i_address;
        o_ready       = i_bus_ready;
      end
      default: begin
        o_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_write_combiner.sv
// Bench for write_combiner: a table of merge vectors, hand-written sequences
// for ordering, priority, reset and stall corners, and a randomized run
// checked against a word-addressed memory model of what the CPU has stored.
`timescale 1ns/1ps
module tb_write_combiner;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          i_reset, i_flush, i_bus_ready, i_rw, i_request;
  logic [31:0]   i_bus_rdata, i_wdata;
  logic [AW-1:0] i_address;
  logic [3:0]    i_wmask;
  logic          o_empty, o_bus_rw, o_bus_request, o_ready;
  logic [AW-1:0] o_bus_address;
  logic [31:0]   o_bus_wdata, o_rdata;
  logic [3:0]    o_bus_wmask;

  always #5 clk = ~clk;

  write_combiner #(.ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush), .o_empty(o_empty),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
    .i_bus_rdata(i_bus_rdata), .i_rw(i_rw), .i_request(i_request), .o_ready(o_ready),
    .i_address(i_address), .i_wdata(i_wdata), .i_wmask(i_wmask), .o_rdata(o_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Downstream memory and transaction log kept by the responder.
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          cycle;
  } bus_txn_t;
  bus_txn_t    bus_log[$];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          bus_delay = 0;
  bit          bus_hold = 1'b0;

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Downstream responder: acknowledges after bus_delay cycles, applies writes
  // to its memory, returns read data, and checks the request drops between
  // transactions.
  initial begin
    int       wait_cnt = 0;
    int       low_cnt = 0;
    bit       prev_req = 1'b0;
    bus_txn_t t;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (o_bus_request) begin
        if (!prev_req) check("bus request gap", 32'(low_cnt >= 1), 32'd1);
        if (!i_bus_ready) begin
          if (!bus_hold && wait_cnt >= bus_delay) begin
            t.rw = o_bus_rw; t.addr = o_bus_address; t.wdata = o_bus_wdata;
            t.wmask = o_bus_wmask; t.cycle = cyc;
            bus_log.push_back(t);
            if (o_bus_rw)
              bus_mem[o_bus_address] = (bus_rd(o_bus_address) & ~lane_mask(o_bus_wmask))
                                     | (o_bus_wdata & lane_mask(o_bus_wmask));
            else
              i_bus_rdata = bus_rd(o_bus_address);
            i_bus_ready = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
        low_cnt = 0;
      end else begin
        i_bus_ready = 1'b0;
        wait_cnt = 0;
        low_cnt++;
      end
      prev_req = o_bus_request;
    end
  end

  // Upstream write; optional simultaneous i_flush, dropped once the flush starts.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input bit with_flush, output int lat, output int ack_cyc);
    bit got = 1'b0;
    bit flush_seen = 1'b0;
    @(posedge clk); #1;
    i_request = 1'b1; i_rw = 1'b1; i_address = a; i_wdata = d; i_wmask = m;
    i_flush = with_flush;
    lat = 0; ack_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_bus_request) flush_seen = 1'b1;
      if (o_ready) begin got = 1'b1; ack_cyc = cyc; break; end
      lat++;
      @(posedge clk); #1;
      if (flush_seen) i_flush = 1'b0;
    end
    if (!got) check("write ack timeout", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_request = 1'b0; i_flush = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] rd);
    bit got = 1'b0;
    @(posedge clk); #1;
    i_request = 1'b1; i_rw = 1'b0; i_address = a;
    rd = 32'h0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_ready) begin got = 1'b1; rd = o_rdata; break; end
    end
    if (!got) check("read ack timeout", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_request = 1'b0;
  endtask

  // Raise i_flush until the bus write starts (or nothing is held).
  task automatic do_flush();
    @(posedge clk); #1;
    i_flush = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_bus_request || o_empty) break;
    end
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic wait_empty();
    bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_empty) begin got = 1'b1; break; end
    end
    if (!got) check("empty timeout", 32'(o_empty), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic [31:0] d1;
    logic [3:0]  m1;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
  } merge_vec_t;

  initial begin
    merge_vec_t  vecs[5];
    int          lat, lat2, ack_cyc, ack2, quiet, stall;
    logic [31:0] rd, a, d;
    logic [3:0]  m;
    bit          got;

    // Two same-address stores followed by timeout; expected word uses zeros
    // in lanes neither store wrote.
    vecs[0] = '{32'h0000_0100, 32'h0000_00AA, 4'b0001, 32'h0000_BB00, 4'b0010, 32'h0000_BBAA, 4'b0011};
    vecs[1] = '{32'h0000_0040, 32'h1122_3344, 4'b1111, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 4'b1111};
    vecs[2] = '{32'h0000_0080, 32'h1234_5678, 4'b1000, 32'h9ABC_DEF0, 4'b1000, 32'h9A00_0000, 4'b1000};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_00FF, 4'b0001, 32'hFF00_0000, 4'b1000, 32'hFF00_00FF, 4'b1001};
    vecs[4] = '{32'h0000_0000, 32'hCAFE_F00D, 4'b0110, 32'h0123_4567, 4'b0100, 32'h0023_F000, 4'b0110};

    i_reset = 1'b1; i_flush = 1'b0; i_rw = 1'b0; i_request = 1'b0;
    i_address = '0; i_wdata = 32'h0; i_wmask = 4'h0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("reset bus_request", 32'(o_bus_request), 32'd0);
    check("reset bus_rw", 32'(o_bus_rw), 32'd0);
    check("reset bus_address", o_bus_address, 32'd0);
    check("reset bus_wdata", o_bus_wdata, 32'd0);
    check("reset bus_wmask", 32'(o_bus_wmask), 32'd0);
    check("reset ready", 32'(o_ready), 32'd0);
    check("reset empty", 32'(o_empty), 32'd1);

    // Merge table: each entry yields one bus write after TO quiet cycles.
    for (int v = 0; v < 5; v++) begin
      bus_log.delete();
      do_write(vecs[v].addr, vecs[v].d0, vecs[v].m0, 1'b0, lat, ack_cyc);
      check("merge first write latency", 32'(lat), 32'd1);
      do_write(vecs[v].addr, vecs[v].d1, vecs[v].m1, 1'b0, lat2, ack_cyc);
      quiet = 0; got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (o_bus_request) begin got = 1'b1; break; end
        if (!o_ready) quiet++;
      end
      check("merge timeout fired", 32'(got), 32'd1);
      check("merge idle cycles", 32'(quiet), 32'(TO));
      wait_empty();
      check("merge bus writes", 32'(bus_log.size()), 32'd1);
      check("merge address", bus_log[0].addr, vecs[v].addr);
      check("merge wdata", bus_log[0].wdata & lane_mask(bus_log[0].wmask), vecs[v].exp_wdata);
      check("merge wmask", 32'(bus_log[0].wmask), 32'(vecs[v].exp_wmask));
    end

    // Mismatch: old word written, one-cycle gap, then the new store acked.
    bus_log.delete();
    do_write(32'h100, 32'h1111_1111, 4'hF, 1'b0, lat, ack_cyc);
    do_write(32'h104, 32'h2222_2222, 4'hF, 1'b0, lat, ack2);
    check("mismatch bus writes", 32'(bus_log.size()), 32'd1);
    check("mismatch address", bus_log[0].addr, 32'h100);
    check("mismatch wdata", bus_log[0].wdata, 32'h1111_1111);
    check("mismatch ack delay", 32'(ack2 - bus_log[0].cycle), 32'd3);
    @(negedge clk);
    check("mismatch empty", 32'(o_empty), 32'd0);
    do_flush(); wait_empty();

    // Read ordering: held write goes out before the read.
    bus_log.delete();
    do_write(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, ack_cyc);
    do_read(32'h200, rd);
    check("order txn count", 32'(bus_log.size()), 32'd2);
    check("order first is write", 32'(bus_log[0].rw), 32'd1);
    check("order second is read", 32'(bus_log[1].rw), 32'd0);
    check("order read address", bus_log[1].addr, 32'h200);
    check("order rdata", rd, 32'hDEAD_BEEF);
    wait_empty();

    // Flush beats a matching store; the store then loads fresh.
    bus_log.delete();
    do_write(32'h300, 32'hAAAA_AAAA, 4'hF, 1'b0, lat, ack_cyc);
    do_write(32'h300, 32'h0000_00CC, 4'b0001, 1'b1, lat, ack_cyc);
    do_flush(); wait_empty();
    check("priority txn count", 32'(bus_log.size()), 32'd2);
    check("priority first wdata", bus_log[0].wdata, 32'hAAAA_AAAA);
    check("priority first wmask", 32'(bus_log[0].wmask), 32'hF);
    check("priority second wmask", 32'(bus_log[1].wmask), 32'b0001);
    check("priority second byte", bus_log[1].wdata & 32'hFF, 32'hCC);

    // Downstream stall during flush.
    do_write(32'h500, 32'h1234_5678, 4'hF, 1'b0, lat, ack_cyc);
    bus_delay = 20;
    @(posedge clk); #1;
    i_request = 1'b1; i_rw = 1'b1; i_address = 32'h504; i_wdata = 32'h0BAD_F00D; i_wmask = 4'hF;
    stall = 0; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_bus_request && o_bus_rw) begin
        check("stall address", o_bus_address, 32'h500);
        check("stall wdata", o_bus_wdata, 32'h1234_5678);
        check("stall wmask", 32'(o_bus_wmask), 32'hF);
        check("stall upstream ready", 32'(o_ready), 32'd0);
        if (!i_bus_ready) stall++;
      end
      if (o_ready) begin got = 1'b1; break; end
    end
    check("stall ack seen", 32'(got), 32'd1);
    check("stall length", 32'(stall >= 20), 32'd1);
    @(posedge clk); #1;
    i_request = 1'b0;
    bus_delay = 0;
    do_flush(); wait_empty();

    // Reset while a flush is stalled: word discarded, nothing written later.
    bus_hold = 1'b1;
    do_write(32'h400, 32'h4444_4444, 4'hF, 1'b0, lat, ack_cyc);
    do_flush();
    repeat (3) @(posedge clk);
    bus_log.delete();
    #1 i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset mid-flush request", 32'(o_bus_request), 32'd0);
    check("reset mid-flush empty", 32'(o_empty), 32'd1);
    @(posedge clk); #1 i_reset = 1'b0;
    bus_hold = 1'b0;
    repeat (30) @(posedge clk);
    check("no write after reset", 32'(bus_log.size()), 32'd0);

    // Randomized traffic against the CPU-view memory model.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      a = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      bus_delay = $urandom_range(0, 3);
      if (op <= 4) begin
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        do_write(a, d, m, 1'b0, lat, ack_cyc);
        ref_mem[a] = (ref_rd(a) & ~lane_mask(m)) | (d & lane_mask(m));
      end else if (op <= 7) begin
        do_read(a, rd);
        check("random read data", rd, ref_rd(a));
      end else if (op == 8) begin
        do_flush();
      end else begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
      end
    end
    do_flush(); wait_empty();
    for (int j = 0; j < 4; j++) begin
      a = 32'h1000 + 32'(4 * j);
      check("random final memory", bus_rd(a), ref_rd(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
